// File: rtl/pad_event_player.sv
// pad_event_player: plays a programmed train of presses on a single button line.
// A start/busy/done handshake latches the hold length, the gap length and the
// repeat count, then plays the train. All durations are counted in prescaled ticks.
// Optional build macro PAD_PLAYER_LOOP_EN adds a 'loop' input. When loop is high
// at the end of the last press, the same latched train is replayed.
module pad_event_player #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned DIV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef PAD_PLAYER_LOOP_EN
    input  logic             loop,
`endif
    input  logic [CNT_W-1:0] hold_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [CNT_W-1:0] reps,
    output logic             button_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP, S_DONE} state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [DIV_W-1:0] r_presc;
    logic [CNT_W-1:0] r_ticks;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_reps;
    logic             r_button;
    logic             r_done;

    logic             w_tick;
    logic             w_hold_end;
    logic             w_gap_end;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_last;
    logic             w_replay;

    // Tick and end-of-phase decode; r_hold and r_gap are never zero after latching.
    assign w_tick      = (r_presc == DIV_LAST);
    assign w_hold_end  = w_tick && (r_ticks == (r_hold - CNT_ONE));
    assign w_gap_end   = w_tick && (r_ticks == (r_gap - CNT_ONE));
    assign w_count_inc = r_count + CNT_ONE;
    assign w_last      = (w_count_inc == r_reps);

`ifdef PAD_PLAYER_LOOP_EN
    assign w_replay = loop;
`else
    assign w_replay = 1'b0;
`endif

    // Sequencer. Registers the state, the counters, the latched fields and the line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_ticks  <= '0;
            r_count  <= '0;
            r_hold   <= '0;
            r_gap    <= '0;
            r_reps   <= '0;
            r_button <= 1'b0;
            r_done   <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_ticks  <= '0;
            r_count  <= '0;
            r_hold   <= '0;
            r_gap    <= '0;
            r_reps   <= '0;
            r_button <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_hold  <= (hold_len == '0) ? CNT_ONE : hold_len;
                        r_gap   <= (gap_len == '0) ? CNT_ONE : gap_len;
                        r_reps  <= reps;
                        r_presc <= '0;
                        r_ticks <= '0;
                        r_count <= '0;
                        if (reps == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_HOLD;
                            r_button <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_hold_end) begin
                        r_presc  <= '0;
                        r_ticks  <= '0;
                        r_button <= 1'b0;
                        if (w_last && !w_replay) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_count <= w_count_inc;
                        end else if (w_last) begin
                            r_state <= S_GAP;
                            r_count <= '0;
                        end else begin
                            r_state <= S_GAP;
                            r_count <= w_count_inc;
                        end
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_ticks <= r_ticks + CNT_ONE;
                    end else begin
                        r_presc <= r_presc + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_presc  <= '0;
                        r_ticks  <= '0;
                        r_state  <= S_HOLD;
                        r_button <= 1'b1;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_ticks <= r_ticks + CNT_ONE;
                    end else begin
                        r_presc <= r_presc + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_count  <= '0;
                    r_button <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_button <= 1'b0;
                end
            endcase
        end
    end

    // busy follows the state directly, so it falls as soon as reset is asserted.
    assign busy       = (r_state != S_IDLE);
    assign button_out = r_button;
    assign done       = r_done;

endmodule

// File: tb/tb_pad_event_player.sv
// Directed bench for pad_event_player. u_dut1 runs with TICK_DIV=1 and u_dut4 runs with TICK_DIV=4.
module tb_pad_event_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1;
    logic       start4;
    logic       abort;
    logic [3:0] hold_len;
    logic [3:0] gap_len;
    logic [3:0] reps;
    logic       btn1, busy1, done1;
    logic       btn4, busy4, done4;
`ifdef PAD_PLAYER_LOOP_EN
    logic       loop_in;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pad_event_player #(.CNT_W(4), .TICK_DIV(1), .DIV_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
`ifdef PAD_PLAYER_LOOP_EN
        .loop(loop_in),
`endif
        .hold_len(hold_len), .gap_len(gap_len), .reps(reps),
        .button_out(btn1), .busy(busy1), .done(done1)
    );

    pad_event_player #(.CNT_W(4), .TICK_DIV(4), .DIV_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort),
`ifdef PAD_PLAYER_LOOP_EN
        .loop(1'b0),
`endif
        .hold_len(hold_len), .gap_len(gap_len), .reps(reps),
        .button_out(btn4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    // Check n consecutive cycles: bit i of each vector is the value expected in the i-th cycle.
    task automatic check_seq(input bit sel, input int n, input logic [31:0] eb,
                             input logic [31:0] ed, input logic [31:0] ey, input string name);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_btn_%0d", name, i), sel ? btn4 : btn1, eb[i]);
            check($sformatf("%s_done_%0d", name, i), sel ? done4 : done1, ed[i]);
            check($sformatf("%s_busy_%0d", name, i), sel ? busy4 : busy1, ey[i]);
            tick();
        end
    endtask

    // Pulse start for one edge; this returns in cycle 1 of the new train.
    task automatic start_train(input bit sel, input logic [3:0] h, input logic [3:0] g,
                               input logic [3:0] r);
        hold_len = h;
        gap_len  = g;
        reps     = r;
        if (sel) start4 = 1'b1;
        else     start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start1 = 1'b0; start4 = 1'b0; abort = 1'b0;
        hold_len = '0; gap_len = '0; reps = '0;
`ifdef PAD_PLAYER_LOOP_EN
        loop_in = 1'b0;
`endif
        #12;
        check("rst_btn1", btn1, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_busy4", busy4, 1'b0);
        rst = 1'b1;
        tick();

        // hold=3 gap=2 reps=2: line is 1 in cycles 1-3, 0 in 4-5, 1 in 6-8; done in cycle 9.
        start_train(1'b0, 4'd3, 4'd2, 4'd2);
        check_seq(1'b0, 10, 32'h0E7, 32'h100, 32'h1FF, "basic");

        // reps=0: no press, done in cycle 1.
        start_train(1'b0, 4'd3, 4'd3, 4'd0);
        check_seq(1'b0, 2, 32'h0, 32'h1, 32'h1, "reps0");

        // hold=0 and gap=0 are treated as 1: pattern 1,0,1,0,1 and then done.
        start_train(1'b0, 4'd0, 4'd0, 4'd3);
        check_seq(1'b0, 7, 32'h15, 32'h20, 32'h3F, "clamp");

        // TICK_DIV=4, hold=2, gap=1, reps=2: 8 cycles pressed, 4 released, 8 pressed.
        start_train(1'b1, 4'd2, 4'd1, 4'd2);
        check_seq(1'b1, 22, 32'h000FF0FF, 32'h00100000, 32'h001FFFFF, "div4");

        // reps=4: start pulsed during the first gap is ignored; abort during the second gap.
        start_train(1'b0, 4'd1, 4'd2, 4'd4);
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("busy_start_btn_c3", btn1, 1'b0);
        check("busy_start_busy_c3", busy1, 1'b1);
        tick();
        check("busy_start_btn_c4", btn1, 1'b1);
        tick();
        check("gap2_btn_c5", btn1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_seq(1'b0, 5, 32'h0, 32'h0, 32'h0, "abort");

        // Abort together with start in IDLE: the start is ignored.
        abort = 1'b1;
        start1 = 1'b1;
        tick();
        abort = 1'b0;
        start1 = 1'b0;
        check("idle_abort_busy", busy1, 1'b0);
        check("idle_abort_btn", btn1, 1'b0);

        // Asynchronous reset in the middle of HOLD, applied between clock edges.
        start_train(1'b0, 4'd4, 4'd1, 4'd2);
        tick();
        check("pre_rst_btn", btn1, 1'b1);
        #3 rst = 1'b0;
        #1;
        check("async_rst_btn", btn1, 1'b0);
        check("async_rst_busy", busy1, 1'b0);
        #2 rst = 1'b1;
        tick();
        start_train(1'b0, 4'd1, 4'd1, 4'd2);
        check_seq(1'b0, 5, 32'h05, 32'h08, 32'h0F, "post_rst");

        // start held high: the next train is accepted in the IDLE cycle after done.
        hold_len = 4'd1; gap_len = 4'd1; reps = 4'd1;
        start1 = 1'b1;
        tick();
        check("held_btn_c1", btn1, 1'b1);
        tick();
        check("held_done_c2", done1, 1'b1);
        tick();
        check("held_busy_c3", busy1, 1'b0);
        tick();
        check("held_btn_c4", btn1, 1'b1);
        start1 = 1'b0;
        tick();
        check("held_done_c5", done1, 1'b1);
        tick();
        check("held_idle_c6", busy1, 1'b0);

`ifdef PAD_PLAYER_LOOP_EN
        // loop=1 replays continuously. Dropping loop in a gap ends the train after the last press.
        loop_in = 1'b1;
        start_train(1'b0, 4'd1, 4'd1, 4'd2);
        check_seq(1'b0, 8, 32'h55, 32'h00, 32'hFF, "loop");
        loop_in = 1'b0;
        check_seq(1'b0, 5, 32'h05, 32'h08, 32'h0F, "loop_end");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
